// File: rtl/compress_pkg.sv
// Shared definitions for the 8-word compressor / decompressor pair:
// tag encodings, flag bit positions, realign FSM states and the tag-size helper.
package compress_pkg;
    localparam int HALF_WIDTH = 16;
    localparam int TAG_BYTES  = 2;

    localparam logic [1:0] TAG_RAW  = 2'b00;
    localparam logic [1:0] TAG_ZERO = 2'b01;
    localparam logic [1:0] TAG_BYTE = 2'b10;
    localparam logic [1:0] TAG_HALF = 2'b11;

    localparam int FLAG_VALID = 3;
    localparam int FLAG_TLAST = 2;
    localparam int FLAG_CPR   = 1;
    localparam int FLAG_HDR   = 0;

    localparam logic [3:0] FLAG_CPR_MASK = 4'b0010;

    typedef enum logic [1:0] {R_IDLE, R_HOLD, R_FLUSH} realign_state_t;

    function automatic logic [2:0] tag2bytes(input logic [1:0] tag);
        case (tag)
            TAG_RAW:  return 3'd4;
            TAG_ZERO: return 3'd0;
            TAG_BYTE: return 3'd1;
            default:  return 3'd2;
        endcase
    endfunction
endpackage

// File: rtl/eight_data_decompress_unit_word_expander.sv
// Restores one 32-bit word from its packed field according to its 2-bit tag.
module word_expander
    import compress_pkg::*;
(
    input  logic [1:0]  i_tag,
    input  logic [31:0] i_field,
    output logic [31:0] o_word
);
    always_comb begin
        case (i_tag)
            TAG_RAW:  o_word = i_field;
            TAG_ZERO: o_word = '0;
            TAG_BYTE: o_word = {{24{i_field[7]}}, i_field[7:0]};
            default:  o_word = {{16{i_field[15]}}, i_field[15:0]};
        endcase
    end
endmodule

// File: rtl/eight_data_decompress_unit.sv
// Decompressor: expands a packed beat into 8 words (stage U), then undoes the
// 16-bit realignment of non-header beats through a hold register (stage R).
module eight_data_decompress_unit
    import compress_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2,
    parameter int LEN_WIDTH  = 8,
    parameter int NUM_WORDS  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0]   data_in,
    input  logic [NUM_WORDS*TAG_WIDTH-1:0]    tag_in,
    input  logic [LEN_WIDTH-1:0]              len_in,
    input  logic [3:0]                        flags_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_WORDS*DATA_WIDTH-1:0]   data_out,
    output logic [3:0]                        flags_out,
    output logic                              len_err
);
    localparam int BW = NUM_WORDS * DATA_WIDTH;
    localparam int HW = HALF_WIDTH;

    logic                                  w_bypass;
    logic                                  w_len_bad;
    logic [NUM_WORDS-1:0][TAG_WIDTH-1:0]   w_tag;
    logic [NUM_WORDS:0][5:0]               w_bsum;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]  w_word;

    // Headers and uncompressed beats pass through as all-raw, which is the identity layout.
    assign w_bypass  = !flags_in[FLAG_CPR] || flags_in[FLAG_HDR];
    assign w_bsum[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] w_field;
            assign w_tag[gi]    = w_bypass ? TAG_RAW : tag_in[gi*TAG_WIDTH +: TAG_WIDTH];
            assign w_bsum[gi+1] = w_bsum[gi] + 6'(tag2bytes(w_tag[gi]));
            assign w_field      = DATA_WIDTH'(data_in >> {w_bsum[gi], 3'b000});
            word_expander u_exp (
                .i_tag   (w_tag[gi]),
                .i_field (w_field),
                .o_word  (w_word[gi])
            );
        end
    endgenerate

    assign w_len_bad = !w_bypass &&
        (len_in != LEN_WIDTH'(w_bsum[NUM_WORDS]) + LEN_WIDTH'(TAG_BYTES));

    logic                 r_live;
    logic                 r_u_vld;
    logic [BW-1:0]        r_u_data;
    logic [3:0]           r_u_flags;
    logic                 r_len_err;
    realign_state_t       r_state;
    logic                 r_flush_hdr;
    logic [BW-1:0]        r_p;
    logic [3:0]           r_pf;
    logic                 r_out_vld;
    logic [BW-1:0]        r_out_data;
    logic [3:0]           r_out_flags;

    logic                 w_out_free;
    logic                 w_r_adv;
    logic                 w_in_fire;
    logic                 w_u_take;
    logic [BW-1:0]        w_p_tail;
    logic [BW-1:0]        w_u_tail;
    logic [BW-1:0]        w_merge;

    assign w_out_free = !r_out_vld || out_ready;
    assign w_r_adv    = w_out_free && (r_state != R_FLUSH);
    assign in_ready   = r_live && !(r_u_vld && !w_r_adv) && (r_state != R_FLUSH);
    assign w_in_fire  = in_valid && in_ready;
    assign w_u_take   = r_u_vld && w_r_adv;

    assign w_p_tail = {{HW{1'b0}}, r_p[BW-1:HW]};
    assign w_u_tail = {{HW{1'b0}}, r_u_data[BW-1:HW]};
    assign w_merge  = {r_u_data[HW-1:0], r_p[BW-1:HW]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live    <= 1'b0;
            r_u_vld   <= 1'b0;
            r_u_data  <= '0;
            r_u_flags <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_live    <= 1'b1;
            r_len_err <= w_in_fire && flags_in[FLAG_VALID] && w_len_bad;
            if (w_in_fire && flags_in[FLAG_VALID]) begin
                r_u_vld   <= 1'b1;
                r_u_data  <= w_word;
                r_u_flags <= flags_in & ~FLAG_CPR_MASK;
            end else if (w_u_take) begin
                r_u_vld <= 1'b0;
            end
        end
    end

    // R_IDLE also means "discard_lo": the next non-header beat loses its low half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= R_IDLE;
            r_flush_hdr <= 1'b0;
            r_p         <= '0;
            r_pf        <= '0;
            r_out_vld   <= 1'b0;
            r_out_data  <= '0;
            r_out_flags <= '0;
        end else begin
            if (out_ready)
                r_out_vld <= 1'b0;
            if (r_state == R_FLUSH) begin
                if (w_out_free) begin
                    r_out_vld   <= 1'b1;
                    r_out_data  <= r_flush_hdr ? r_p : w_p_tail;
                    r_out_flags <= r_pf;
                    r_state     <= R_IDLE;
                end
            end else if (w_u_take) begin
                if (r_u_flags[FLAG_HDR]) begin
                    r_out_vld <= 1'b1;
                    if (r_state == R_HOLD) begin
                        r_out_data  <= w_p_tail;
                        r_out_flags <= r_pf;
                        r_p         <= r_u_data;
                        r_pf        <= r_u_flags;
                        r_flush_hdr <= 1'b1;
                        r_state     <= R_FLUSH;
                    end else begin
                        r_out_data  <= r_u_data;
                        r_out_flags <= r_u_flags;
                    end
                end else if (r_state == R_HOLD) begin
                    r_out_vld   <= 1'b1;
                    r_out_data  <= w_merge;
                    r_out_flags <= r_pf;
                    r_p         <= r_u_data;
                    r_pf        <= r_u_flags;
                    if (r_u_flags[FLAG_TLAST]) begin
                        r_flush_hdr <= 1'b0;
                        r_state     <= R_FLUSH;
                    end
                end else if (r_u_flags[FLAG_TLAST]) begin
                    r_out_vld   <= 1'b1;
                    r_out_data  <= w_u_tail;
                    r_out_flags <= r_u_flags;
                end else begin
                    r_p     <= r_u_data;
                    r_pf    <= r_u_flags;
                    r_state <= R_HOLD;
                end
            end
        end
    end

    assign out_valid = r_out_vld;
    assign data_out  = r_out_data;
    assign flags_out = r_out_flags;
    assign len_err   = r_len_err;
endmodule

// File: tb/tb_eight_data_decompress_unit.sv
// Directed scoreboard bench for eight_data_decompress_unit.
module tb_eight_data_decompress_unit;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] data_in = '0;
    logic [15:0]  tag_in = '0;
    logic [7:0]   len_in = '0;
    logic [3:0]   flags_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] data_out;
    logic [3:0]   flags_out;
    logic         len_err;

    eight_data_decompress_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .tag_in(tag_in), .len_in(len_in), .flags_in(flags_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .flags_out(flags_out), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    logic [259:0] q[$];
    logic         m_pend = 1'b0;
    logic [255:0] m_p = '0;
    logic [3:0]   m_pf = '0;
    int           m_lerr = 0;
    int           lerr_cnt = 0;
    int           lerr_long = 0;
    logic         prev_lerr = 1'b0;
    logic         prev_stall = 1'b0;
    logic [259:0] prev_out = '0;

    task automatic check(input string tag, input logic [259:0] obs, input logic [259:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [255:0] expand_ref(input logic [255:0] d, input logic [15:0] t,
                                                input logic [3:0] f, output int nbytes);
        logic [255:0] w;
        logic [255:0] s;
        logic [1:0]   tg;
        int           pos;
        w = '0;
        pos = 0;
        for (int i = 0; i < 8; i++) begin
            tg = (f[1] && !f[0]) ? t[2*i +: 2] : 2'b00;
            s = d >> pos;
            case (tg)
                2'b00: begin w[32*i +: 32] = s[31:0]; pos += 32; end
                2'b01: ;
                2'b10: begin w[32*i +: 32] = {{24{s[7]}}, s[7:0]}; pos += 8; end
                default: begin w[32*i +: 32] = {{16{s[15]}}, s[15:0]}; pos += 16; end
            endcase
        end
        nbytes = pos / 8;
        return w;
    endfunction

    task automatic model_in(input logic [255:0] d, input logic [15:0] t,
                            input logic [7:0] l, input logic [3:0] f);
        logic [255:0] w;
        logic [3:0]   fo;
        int           nb;
        if (!f[3]) return;
        w  = expand_ref(d, t, f, nb);
        fo = f & 4'b1101;
        if (f[1] && !f[0] && l != 8'(nb + 2)) m_lerr++;
        if (f[0]) begin
            if (m_pend) q.push_back({m_pf, 16'h0, m_p[255:16]});
            q.push_back({fo, w});
            m_pend = 1'b0;
        end else if (m_pend) begin
            q.push_back({m_pf, w[15:0], m_p[255:16]});
            if (f[2]) begin
                q.push_back({fo, 16'h0, w[255:16]});
                m_pend = 1'b0;
            end else begin
                m_p = w; m_pf = fo;
            end
        end else if (f[2]) begin
            q.push_back({fo, 16'h0, w[255:16]});
        end else begin
            m_p = w; m_pf = fo; m_pend = 1'b1;
        end
    endtask

    task automatic send(input logic [255:0] d, input logic [15:0] t, input logic [7:0] l,
                        input logic [3:0] f, input bit mdl);
        int n;
        n = 0;
        if (mdl) model_in(d, t, l, f);
        data_in = d; tag_in = t; len_in = l; flags_in = f; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_accept", 260'(in_ready), 260'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_drain"}, 260'(q.size()), 260'(0));
        check({tag, "_len_err_count"}, 260'(lerr_cnt), 260'(m_lerr));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_lerr  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 260'(out_valid), 260'(1));
                check("stall_stable", {flags_out, data_out}, prev_out);
            end
            if (out_valid && out_ready) begin
                total++;
                assert (q.size() != 0) passed++;
                else $error("FAIL extra_beat observed=%h expected=none", {flags_out, data_out});
                if (q.size() != 0) check("out_beat", {flags_out, data_out}, q.pop_front());
            end
            if (len_err) lerr_cnt++;
            if (len_err && prev_lerr) lerr_long++;
            prev_lerr  = len_err;
            prev_stall = out_valid && !out_ready;
            prev_out   = {flags_out, data_out};
        end
    end

    initial begin
        logic [255:0] h, b, d;
        logic [255:0] w3;
        int           nb;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 260'(out_valid), 260'(0));
        check("rst_in_ready", 260'(in_ready), 260'(0));
        check("rst_data_out", 260'(data_out), 260'(0));
        check("rst_flags_out", 260'(flags_out), 260'(0));
        check("rst_len_err", 260'(len_err), 260'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 260'(in_ready), 260'(1));

        // 1: header verbatim, first raw beat loses its low half
        h = {{31{8'hAA}}, 8'hA1};
        b = {{30{8'h3C}}, 16'hA1A1};
        send(h, 16'h0, 8'd32, 4'b1001, 1'b1);
        @(posedge clk);
        #1;
        check("hdr_latency", {3'b0, out_valid, flags_out, data_out}, {4'b0001, 4'b1001, h});
        send(b, 16'h0, 8'd32, 4'b1100, 1'b1);
        drain("t1");

        // 2: all-zero compressed beats with garbage payload, plus a dropped invalid beat
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send(d, 16'h5555, 8'd2, 4'b1010, 1'b1);
        send(~d, 16'h5555, 8'd2, 4'b0110, 1'b1);
        send(~d, 16'h5555, 8'd2, 4'b1110, 1'b1);
        drain("t2");

        // 3: mixed tags, expectations written out by hand
        d = '0;
        d[31:0]   = 32'h12345678;
        d[39:32]  = 8'h80;
        d[55:40]  = 16'h7FFF;
        d[87:56]  = 32'hDEADBEEF;
        d[95:88]  = 8'h05;
        d[111:96] = 16'h8001;
        w3 = {32'hFFFF8001, 32'h00000005, 32'h0, 32'hDEADBEEF,
              32'h00007FFF, 32'hFFFFFF80, 32'h0, 32'h12345678};
        h = {8{32'h0BADF00D}};
        send(h, 16'h0, 8'd32, 4'b1001, 1'b0);
        q.push_back({4'b1001, h});
        send(d, 16'hE4E4, 8'd16, 4'b1010, 1'b0);
        send(d, 16'hE4E4, 8'd16, 4'b1110, 1'b0);
        q.push_back({4'b1000, w3[15:0], w3[255:16]});
        q.push_back({4'b1100, 16'h0, w3[255:16]});
        drain("t3");

        // 4: length mismatch still restores data
        send(d, 16'hE4E4, 8'd15, 4'b1110, 1'b1);
        drain("t4");
        check("t4_single_pulse", 260'(lerr_long), 260'(0));
        void'(expand_ref(d, 16'hE4E4, 4'b1010, nb));

        // 5: output backpressure mid-stream, header flush of a pending beat
        send({8{$urandom}}, 16'h0, 8'd32, 4'b1001, 1'b1);
        send({8{$urandom}}, 16'h0, 8'd32, 4'b1000, 1'b1);
        send({8{$urandom}}, 16'h0, 8'd32, 4'b1000, 1'b1);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        send({8{$urandom}}, 16'h0, 8'd32, 4'b1000, 1'b1);
        send({8{$urandom}}, 16'h0, 8'd32, 4'b1001, 1'b1);
        send({8{$urandom}}, 16'h0, 8'd32, 4'b1000, 1'b1);
        send({8{$urandom}}, 16'h0, 8'd32, 4'b1100, 1'b1);
        drain("t5");

        // 6: reset with a pending beat, then a clean packet
        send({8{32'h5A5A5A5A}}, 16'h0, 8'd32, 4'b1001, 1'b1);
        send({8{32'hC3C3C3C3}}, 16'h0, 8'd32, 4'b1000, 1'b1);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 260'(out_valid), 260'(0));
        check("mid_rst_data_out", 260'(data_out), 260'(0));
        check("mid_rst_flags_out", 260'(flags_out), 260'(0));
        check("mid_rst_in_ready", 260'(in_ready), 260'(0));
        q.delete();
        m_pend = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_release_in_ready", 260'(in_ready), 260'(1));
        send({8{32'h11223344}}, 16'h0, 8'd32, 4'b1001, 1'b1);
        send({8{32'h99887766}}, 16'h0, 8'd32, 4'b1100, 1'b1);
        drain("t6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
